// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32I instruction decode, bypassed register file and ID/EX
//            pipeline register with stall, flush, valid and illegal tracking.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           InstrD,
    input  logic [XLEN-1:0]       PCD,
    input  logic [XLEN-1:0]       PCPlus4D,
    input  logic                  ValidD,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  RegWriteW,
    input  logic [AW-1:0]         RDW,
    input  logic [XLEN-1:0]       ResultW,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic                  ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic [1:0]            ResultSrcE,
    output logic [3:0]            ALUControlE,
    output logic [2:0]            Funct3E,
    output logic [XLEN-1:0]       RD1E,
    output logic [XLEN-1:0]       RD2E,
    output logic [XLEN-1:0]       ImmExtE,
    output logic [XLEN-1:0]       PCE,
    output logic [XLEN-1:0]       PCPlus4E,
    output logic [AW-1:0]         RdE,
    output logic [AW-1:0]         Rs1E,
    output logic [AW-1:0]         Rs2E,
    output logic                  ValidE,
    output logic                  IllegalE,
    output logic [NREGS*XLEN-1:0] debug_regs_flat
);

    localparam logic [3:0] c_ADD = 4'b0000, c_SUB = 4'b0001, c_SLL = 4'b0010,
                           c_SLT = 4'b0011, c_SLTU = 4'b0100, c_XOR = 4'b0101,
                           c_SRL = 4'b0110, c_SRA = 4'b0111, c_OR = 4'b1000,
                           c_AND = 4'b1001, c_PASSB = 4'b1010;
    localparam logic [6:0] c_OP_R = 7'b0110011, c_OP_I = 7'b0010011,
                           c_OP_LOAD = 7'b0000011, c_OP_STORE = 7'b0100011,
                           c_OP_BR = 7'b1100011, c_OP_JAL = 7'b1101111,
                           c_OP_JALR = 7'b1100111, c_OP_LUI = 7'b0110111,
                           c_OP_AUIPC = 7'b0010111;
    localparam logic [5:0] c_NREGS = 6'(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];

    logic [6:0]      w_op, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic            w_rw, w_mw, w_br, w_jmp, w_srca, w_srcb, w_ill;
    logic            w_use_rs1, w_use_rs2, w_use_rd;
    logic [1:0]      w_ressrc;
    logic [3:0]      w_alu, w_f3_alu;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm, w_rd1, w_rd2;
    logic [AW-1:0]   w_ra1, w_ra2;

    assign w_op  = InstrD[6:0];
    assign w_rd  = InstrD[11:7];
    assign w_f3  = InstrD[14:12];
    assign w_rs1 = InstrD[19:15];
    assign w_rs2 = InstrD[24:20];
    assign w_f7  = InstrD[31:25];

    always_comb begin
        case (w_f3)
            3'b000:  w_f3_alu = c_ADD;
            3'b001:  w_f3_alu = c_SLL;
            3'b010:  w_f3_alu = c_SLT;
            3'b011:  w_f3_alu = c_SLTU;
            3'b100:  w_f3_alu = c_XOR;
            3'b101:  w_f3_alu = c_SRL;
            3'b110:  w_f3_alu = c_OR;
            default: w_f3_alu = c_AND;
        endcase
    end

    always_comb begin
        w_rw = 1'b0; w_mw = 1'b0; w_br = 1'b0; w_jmp = 1'b0;
        w_srca = 1'b0; w_srcb = 1'b0; w_ressrc = 2'b00; w_alu = c_ADD;
        w_use_rs1 = 1'b0; w_use_rs2 = 1'b0; w_use_rd = 1'b0; w_ill = 1'b0;
        w_imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
        case (w_op)
            c_OP_R: begin
                w_rw = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
                if (w_f7 == 7'b0000000)
                    w_alu = w_f3_alu;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b000)
                    w_alu = c_SUB;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b101)
                    w_alu = c_SRA;
                else
                    w_ill = 1'b1;
            end
            c_OP_I: begin
                w_rw = 1'b1; w_srcb = 1'b1; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_alu = w_f3_alu;
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000)
                    w_ill = 1'b1;
                if (w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0100000)
                        w_alu = c_SRA;
                    else if (w_f7 != 7'b0000000)
                        w_ill = 1'b1;
                end
            end
            c_OP_LOAD: begin
                w_rw = 1'b1; w_srcb = 1'b1; w_ressrc = 2'b01;
                w_use_rs1 = 1'b1; w_use_rd = 1'b1;
            end
            c_OP_STORE: begin
                w_mw = 1'b1; w_srcb = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            c_OP_BR: begin
                w_br = 1'b1; w_alu = c_SUB; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            end
            c_OP_JAL: begin
                w_rw = 1'b1; w_jmp = 1'b1; w_ressrc = 2'b10; w_use_rd = 1'b1;
                w_imm32 = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            end
            c_OP_JALR: begin
                w_rw = 1'b1; w_jmp = 1'b1; w_srcb = 1'b1; w_ressrc = 2'b10;
                w_use_rs1 = 1'b1; w_use_rd = 1'b1;
            end
            c_OP_LUI: begin
                w_rw = 1'b1; w_srcb = 1'b1; w_alu = c_PASSB; w_use_rd = 1'b1;
                w_imm32 = {InstrD[31:12], 12'b0};
            end
            c_OP_AUIPC: begin
                w_rw = 1'b1; w_srca = 1'b1; w_srcb = 1'b1; w_use_rd = 1'b1;
                w_imm32 = {InstrD[31:12], 12'b0};
            end
            default: w_ill = 1'b1;
        endcase
        // Register indices beyond the implemented file (RV32E) trap.
        if ((w_use_rs1 && {1'b0, w_rs1} >= c_NREGS) ||
            (w_use_rs2 && {1'b0, w_rs2} >= c_NREGS) ||
            (w_use_rd  && {1'b0, w_rd}  >= c_NREGS))
            w_ill = 1'b1;
        if (w_ill) begin
            w_rw = 1'b0; w_mw = 1'b0; w_br = 1'b0; w_jmp = 1'b0;
        end
    end

    assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};
    assign w_ra1 = w_rs1[AW-1:0];
    assign w_ra2 = w_rs2[AW-1:0];

    // Same-cycle writeback is forwarded so Decode never sees a stale value.
    assign w_rd1 = (w_ra1 == '0) ? '0 :
                   (RegWriteW && RDW == w_ra1) ? ResultW : r_regs[w_ra1];
    assign w_rd2 = (w_ra2 == '0) ? '0 :
                   (RegWriteW && RDW == w_ra2) ? ResultW : r_regs[w_ra2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (RegWriteW && RDW != '0) begin
            r_regs[RDW] <= ResultW;
        end
    end

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_dbg
            assign debug_regs_flat[g*XLEN +: XLEN] = r_regs[g];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst || FlushE || (!StallE && !ValidD)) begin
            RegWriteE <= 1'b0; MemWriteE <= 1'b0; BranchE <= 1'b0; JumpE <= 1'b0;
            ALUSrcAE <= 1'b0; ALUSrcBE <= 1'b0; ResultSrcE <= '0; ALUControlE <= '0;
            Funct3E <= '0; RD1E <= '0; RD2E <= '0; ImmExtE <= '0; PCE <= '0;
            PCPlus4E <= '0; RdE <= '0; Rs1E <= '0; Rs2E <= '0;
            ValidE <= 1'b0; IllegalE <= 1'b0;
        end else if (!StallE) begin
            RegWriteE <= w_rw; MemWriteE <= w_mw; BranchE <= w_br; JumpE <= w_jmp;
            ALUSrcAE <= w_srca; ALUSrcBE <= w_srcb; ResultSrcE <= w_ressrc;
            ALUControlE <= w_alu; Funct3E <= w_f3; RD1E <= w_rd1; RD2E <= w_rd2;
            ImmExtE <= w_imm; PCE <= PCD; PCPlus4E <= PCPlus4D;
            RdE <= w_rd[AW-1:0]; Rs1E <= w_ra1; Rs2E <= w_ra2;
            ValidE <= 1'b1; IllegalE <= w_ill;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage (XLEN=32, NREGS=16).
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int NREGS = 16;
    localparam int AW = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
    logic ValidD = 1'b0, StallE = 1'b0, FlushE = 1'b0, RegWriteW = 1'b0;
    logic [AW-1:0] RDW = '0;
    logic RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE, ALUSrcBE, ValidE, IllegalE;
    logic [1:0] ResultSrcE;
    logic [3:0] ALUControlE;
    logic [2:0] Funct3E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [AW-1:0] RdE, Rs1E, Rs2E;
    logic [NREGS*XLEN-1:0] debug_regs_flat;

    decode_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW),
        .RDW(RDW), .ResultW(ResultW), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .ValidE(ValidE), .IllegalE(IllegalE),
        .debug_regs_flat(debug_regs_flat)
    );

    always #5 clk = ~clk;

    // Control vector: {RW,MW,BR,J,SRCA,SRCB,RESSRC[1:0],ALU[3:0],VALID,ILLEGAL}
    localparam logic [13:0] c_ALL = 14'h3FFF;
    localparam logic [13:0] c_ILL = 14'b11110000000011;
    localparam logic [13:0] c_NOALU = 14'b11111111000011;

    typedef struct packed {
        logic [13:0] ctl;
        logic [13:0] mask;
        logic        chk_ops;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        chk_imm;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic exp_t mk(input logic [13:0] ctl, input logic [13:0] mask,
                                input logic chk_ops, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic chk_imm,
                                input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        e.ctl = ctl; e.mask = mask; e.chk_ops = chk_ops; e.rd1 = rd1; e.rd2 = rd2;
        e.chk_imm = chk_imm; e.imm = imm; e.pc = pc;
        return e;
    endfunction

    function automatic logic [13:0] ctl(input logic rw, mw, br, j, sa, sb,
                                        input logic [1:0] rs, input logic [3:0] alu,
                                        input logic v, il);
        return {rw, mw, br, j, sa, sb, rs, alu, v, il};
    endfunction

    // Drive one Decode cycle at the negedge, then compare after the posedge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic valid, input logic stall, input logic flush,
                         input exp_t e);
        exp_t x;
        logic [13:0] got;
        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
        ValidD = valid; StallE = stall; FlushE = flush;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            x = sb_q.pop_front();
            got = {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE, ALUSrcBE,
                   ResultSrcE, ALUControlE, ValidE, IllegalE};
            check("ctl", 64'(got & x.mask), 64'(x.ctl & x.mask));
            check("pc", 64'(PCE), 64'(x.pc));
            if (x.chk_ops) begin
                check("rd1", 64'(RD1E), 64'(x.rd1));
                check("rd2", 64'(RD2E), 64'(x.rd2));
            end
            if (x.chk_imm)
                check("imm", 64'(ImmExtE), 64'(x.imm));
        end
        @(negedge clk);
        StallE = 1'b0; FlushE = 1'b0;
    endtask

    exp_t e_zero, e_lui;

    initial begin
        e_zero = mk(14'd0, c_ALL, 1'b1, 32'd0, 32'd0, 1'b1, 32'd0, 32'd0);

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(ValidE), 64'd0);
        check("rst_ctl", 64'({RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE,
                              ALUSrcBE, ResultSrcE, ALUControlE, IllegalE}), 64'd0);
        check("rst_data", 64'(|{RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E, Funct3E}), 64'd0);
        check("rst_regs", 64'(|debug_regs_flat), 64'd0);
        rst = 1'b0;

        // add x6,x5,x5 while x5 <= 0x1234 is written back in the same cycle
        RegWriteW = 1'b1; RDW = 4'd5; ResultW = 32'h1234;
        issue(32'h00528333, 32'h100, 1'b1, 1'b0, 1'b0,
              mk(ctl(1,0,0,0,0,0,2'b00,4'b0000,1,0), c_ALL, 1'b1, 32'h1234, 32'h1234, 1'b0, 32'd0, 32'h100));
        RegWriteW = 1'b0;
        check("rd_idx", 64'(RdE), 64'd6);
        check("rs1_idx", 64'(Rs1E), 64'd5);
        check("x5_written", 64'(debug_regs_flat[5*32 +: 32]), 64'h1234);

        issue(32'h40315093, 32'h104, 1'b1, 1'b0, 1'b0,   // srai x1,x2,3
              mk(ctl(1,0,0,0,0,1,2'b00,4'b0111,1,0), c_ALL, 1'b1, 32'd0, 32'd0, 1'b1, 32'h403, 32'h104));
        e_lui = mk(ctl(1,0,0,0,0,1,2'b00,4'b1010,1,0), c_ALL, 1'b0, 32'd0, 32'd0, 1'b1, 32'hABCDE000, 32'h108);
        issue(32'hABCDE1B7, 32'h108, 1'b1, 1'b0, 1'b0, e_lui); // lui x3,0xABCDE
        issue(32'hFFC100E7, 32'h10C, 1'b1, 1'b0, 1'b0,   // jalr x1,-4(x2)
              mk(ctl(1,0,0,1,0,1,2'b10,4'b0000,1,0), c_ALL, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFC, 32'h10C));
        issue(32'h12345217, 32'h110, 1'b1, 1'b0, 1'b0,   // auipc x4,0x12345
              mk(ctl(1,0,0,0,1,1,2'b00,4'b0000,1,0), c_ALL, 1'b0, 32'd0, 32'd0, 1'b1, 32'h12345000, 32'h110));
        issue(32'h00532423, 32'h114, 1'b1, 1'b0, 1'b0,   // sw x5,8(x6)
              mk(ctl(0,1,0,0,0,1,2'b00,4'b0000,1,0), c_ALL, 1'b1, 32'd0, 32'h1234, 1'b1, 32'd8, 32'h114));
        issue(32'hFE528CE3, 32'h118, 1'b1, 1'b0, 1'b0,   // beq x5,x5,-8
              mk(ctl(0,0,1,0,0,0,2'b00,4'b0001,1,0), c_ALL, 1'b1, 32'h1234, 32'h1234, 1'b1, 32'hFFFFFFF8, 32'h118));
        issue(32'h010000EF, 32'h11C, 1'b1, 1'b0, 1'b0,   // jal x1,16
              mk(ctl(1,0,0,1,0,0,2'b10,4'b0000,1,0), c_NOALU, 1'b0, 32'd0, 32'd0, 1'b1, 32'd16, 32'h11C));
        issue(32'hC0000093, 32'h120, 1'b1, 1'b0, 1'b0,   // addi x1,x0,-1024: funct7-like bits ignored
              mk(ctl(1,0,0,0,0,1,2'b00,4'b0000,1,0), c_ALL, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFFFC00, 32'h120));
        issue(32'h00528333, 32'h124, 1'b0, 1'b0, 1'b0, e_zero);  // ValidD=0 bubble

        // Illegal encodings
        issue(32'h002088B3, 32'h128, 1'b1, 1'b0, 1'b0,   // add x17,x1,x2 with NREGS=16
              mk(ctl(0,0,0,0,0,0,2'b00,4'b0000,1,1), c_ILL, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h128));
        issue(32'h0000007F, 32'h12C, 1'b1, 1'b0, 1'b0,
              mk(ctl(0,0,0,0,0,0,2'b00,4'b0000,1,1), c_ILL, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h12C));
        issue(32'h02000033, 32'h130, 1'b1, 1'b0, 1'b0,   // R-type funct7 0000001
              mk(ctl(0,0,0,0,0,0,2'b00,4'b0000,1,1), c_ILL, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h130));
        issue(32'h40009093, 32'h134, 1'b1, 1'b0, 1'b0,   // slli with funct7 0100000
              mk(ctl(0,0,0,0,0,0,2'b00,4'b0000,1,1), c_ILL, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h134));

        // Writes to x0 are dropped and never bypassed
        RegWriteW = 1'b1; RDW = 4'd0; ResultW = 32'hDEAD;
        issue(32'h00000333, 32'h138, 1'b1, 1'b0, 1'b0,   // add x6,x0,x0
              mk(ctl(1,0,0,0,0,0,2'b00,4'b0000,1,0), c_ALL, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 32'h138));
        RegWriteW = 1'b0;
        check("x0_zero", 64'(debug_regs_flat[31:0]), 64'd0);

        // Stall holds two cycles while the register file still writes; flush beats stall
        e_lui.pc = 32'h200;
        issue(32'hABCDE1B7, 32'h200, 1'b1, 1'b0, 1'b0, e_lui);
        RegWriteW = 1'b1; RDW = 4'd7; ResultW = 32'h77;
        issue(32'h12345217, 32'h300, 1'b1, 1'b1, 1'b0, e_lui);
        RegWriteW = 1'b0;
        issue(32'h12345217, 32'h304, 1'b1, 1'b1, 1'b0, e_lui);
        check("x7_stall_wr", 64'(debug_regs_flat[7*32 +: 32]), 64'h77);
        issue(32'h12345217, 32'h308, 1'b1, 1'b1, 1'b1, e_zero);

        // Asynchronous reset between edges
        issue(32'h00528333, 32'h140, 1'b1, 1'b0, 1'b0,
              mk(ctl(1,0,0,0,0,0,2'b00,4'b0000,1,0), c_ALL, 1'b1, 32'h1234, 32'h1234, 1'b0, 32'd0, 32'h140));
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(ValidE), 64'd0);
        check("arst_rw", 64'(RegWriteE), 64'd0);
        check("arst_regs", 64'(|debug_regs_flat), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'h00528333, 32'h144, 1'b1, 1'b0, 1'b0,
              mk(ctl(1,0,0,0,0,0,2'b00,4'b0000,1,0), c_ALL, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 32'h144));

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
